// File: rtl/string_match_controller.sv
// Packet-level sequencer for a bank of string comparators: holds host-programmed
// flagged strings, frames packets, samples sticky match results and reports them.
module string_match_controller #(
  parameter int unsigned NUM_STRINGS  = 4,
  parameter int unsigned IDXW         = 4,
  parameter int unsigned DRAIN_CYCLES = 2
) (
  input  logic                       clk,
  input  logic                       n_rst,
  input  logic                       prog_wr,
  input  logic [IDXW-1:0]            prog_idx,
  input  logic [135:0]               prog_string,
  input  logic [4:0]                 prog_strlen,
  input  logic                       prog_en,
  output logic                       prog_ready,
  input  logic                       pkt_start,
  input  logic                       pkt_valid,
  input  logic                       pkt_end,
  output logic                       pkt_ready,
  output logic [NUM_STRINGS*136-1:0] comp_strings,
  output logic [NUM_STRINGS*5-1:0]   comp_strlens,
  output logic                       comp_clear,
  input  logic [NUM_STRINGS-1:0]     comp_match,
  output logic                       res_valid,
  input  logic                       res_ready,
  output logic                       res_flagged,
  output logic [NUM_STRINGS-1:0]     res_mask,
  output logic [IDXW-1:0]            res_idx,
  output logic [15:0]                pkt_count,
  output logic [15:0]                flag_count
);

  localparam int unsigned StrW = 136;
  localparam int unsigned CntW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

  typedef enum logic [2:0] {StIdle, StActive, StDrain, StReport, StClear} state_e;

  state_e                 state_q, state_d;
  logic [StrW-1:0]        str_q [NUM_STRINGS];
  logic [StrW-1:0]        str_d [NUM_STRINGS];
  logic [4:0]             len_q [NUM_STRINGS];
  logic [4:0]             len_d [NUM_STRINGS];
  logic [NUM_STRINGS-1:0] en_q, en_d;
  logic [CntW-1:0]        cnt_q, cnt_d;
  logic                   res_flagged_q, res_flagged_d;
  logic [NUM_STRINGS-1:0] res_mask_q, res_mask_d;
  logic [IDXW-1:0]        res_idx_q, res_idx_d;
  logic [15:0]            pkt_count_q, pkt_count_d;
  logic [15:0]            flag_count_q, flag_count_d;

  logic [NUM_STRINGS-1:0] valid_mask, hit;
  logic [IDXW-1:0]        hit_idx;

  // Zero-length comparators match trivially, so they must never reach the result.
  always_comb begin
    valid_mask = '0;
    hit_idx    = '0;
    for (int i = 0; i < int'(NUM_STRINGS); i++) begin
      valid_mask[i] = en_q[i] && (len_q[i] != 5'd0) && (len_q[i] <= 5'd17);
    end
    hit = comp_match & valid_mask;
    for (int i = int'(NUM_STRINGS) - 1; i >= 0; i--) begin
      if (hit[i]) hit_idx = IDXW'(i);
    end
  end

  // Out-of-range indices match no slot, so such writes are silently dropped.
  always_comb begin
    str_d      = str_q;
    len_d      = len_q;
    en_d       = en_q;
    prog_ready = (state_q == StIdle);
    if (prog_wr && prog_ready) begin
      for (int i = 0; i < int'(NUM_STRINGS); i++) begin
        if (prog_idx == IDXW'(i)) begin
          str_d[i] = prog_string;
          len_d[i] = prog_strlen;
          en_d[i]  = prog_en;
        end
      end
    end
  end

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    res_flagged_d = res_flagged_q;
    res_mask_d    = res_mask_q;
    res_idx_d     = res_idx_q;
    pkt_count_d   = pkt_count_q;
    flag_count_d  = flag_count_q;
    pkt_ready     = 1'b0;
    res_valid     = 1'b0;
    comp_clear    = 1'b0;
    unique case (state_q)
      StIdle: begin
        pkt_ready = 1'b1;
        if (pkt_valid && pkt_start) begin
          state_d = pkt_end ? StDrain : StActive;
          cnt_d   = '0;
        end
      end
      StActive: begin
        pkt_ready = 1'b1;
        // A fresh start closes the current packet; the new one is not captured.
        if (pkt_valid && (pkt_end || pkt_start)) begin
          state_d = StDrain;
          cnt_d   = '0;
        end
      end
      StDrain: begin
        if (cnt_q == CntW'(DRAIN_CYCLES - 1)) begin
          res_mask_d    = hit;
          res_flagged_d = |hit;
          res_idx_d     = hit_idx;
          state_d       = StReport;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StReport: begin
        res_valid = 1'b1;
        if (res_ready) begin
          if (pkt_count_q != 16'hFFFF) pkt_count_d = pkt_count_q + 16'd1;
          if (res_flagged_q && (flag_count_q != 16'hFFFF)) flag_count_d = flag_count_q + 16'd1;
          state_d = StClear;
        end
      end
      StClear: begin
        comp_clear = 1'b1;
        state_d    = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q       <= StIdle;
      en_q          <= '0;
      cnt_q         <= '0;
      res_flagged_q <= 1'b0;
      res_mask_q    <= '0;
      res_idx_q     <= '0;
      pkt_count_q   <= '0;
      flag_count_q  <= '0;
      for (int i = 0; i < int'(NUM_STRINGS); i++) begin
        str_q[i] <= '0;
        len_q[i] <= '0;
      end
    end else begin
      state_q       <= state_d;
      en_q          <= en_d;
      cnt_q         <= cnt_d;
      res_flagged_q <= res_flagged_d;
      res_mask_q    <= res_mask_d;
      res_idx_q     <= res_idx_d;
      pkt_count_q   <= pkt_count_d;
      flag_count_q  <= flag_count_d;
      for (int i = 0; i < int'(NUM_STRINGS); i++) begin
        str_q[i] <= str_d[i];
        len_q[i] <= len_d[i];
      end
    end
  end

  for (genvar g = 0; g < int'(NUM_STRINGS); g++) begin : g_comp
    assign comp_strings[g*StrW +: StrW] = str_q[g];
    assign comp_strlens[g*5 +: 5]       = len_q[g];
  end

  assign res_flagged = res_flagged_q;
  assign res_mask    = res_mask_q;
  assign res_idx     = res_idx_q;
  assign pkt_count   = pkt_count_q;
  assign flag_count  = flag_count_q;

endmodule
